// File: rtl/tage_pkg.sv
// Shared types and saturating-counter helpers for the TAGE base predictor.
// Pure declarations: no latency and no flow control.
package tage_pkg;

  localparam int TAGE_BASE_NUM_ENTRIES = 512;
  localparam int TAGE_BASE_CTR_WIDTH   = 2;
  localparam int TAGE_CTR_MAX_WIDTH    = 4;

  typedef logic [TAGE_CTR_MAX_WIDTH-1:0] ctr_max_t;

  typedef enum logic {
    INIT,
    RUN
  } tage_base_state_e;

  // Counters narrower than TAGE_CTR_MAX_WIDTH are carried zero-extended; w selects the real width.
  function automatic ctr_max_t sat_max(input int unsigned w);
    return ctr_max_t'((1 << w) - 1);
  endfunction

  function automatic ctr_max_t sat_inc(input ctr_max_t v, input int unsigned w);
    ctr_max_t top;
    top = sat_max(w);
    return (v >= top) ? top : ctr_max_t'(v + 1'b1);
  endfunction

  function automatic ctr_max_t sat_dec(input ctr_max_t v, input int unsigned w);
    return (v == '0) ? '0 : ctr_max_t'(v - 1'b1);
  endfunction

endpackage

// File: rtl/tage_base_table_if.sv
// Predictor-client <-> base-table bundle: lookup, response, update and init control.
// Valid-only signalling; the table never back-pressures.
interface tage_base_table_if
  import tage_pkg::*;
#(
  parameter int IDX_WIDTH = $clog2(TAGE_BASE_NUM_ENTRIES),
  parameter int CTR_WIDTH = TAGE_BASE_CTR_WIDTH
);

  logic                 soft_init;
  logic                 init_busy;
  logic                 pred_valid;
  logic [IDX_WIDTH-1:0] pred_idx;
  logic                 pred_resp_valid;
  logic [CTR_WIDTH-1:0] pred_ctr;
  logic                 pred_taken;
  logic                 upd_valid;
  logic [IDX_WIDTH-1:0] upd_idx;
  logic                 upd_taken;
  logic [CTR_WIDTH-1:0] upd_ctr_old;

  modport master (
    output soft_init, pred_valid, pred_idx, upd_valid, upd_idx, upd_taken, upd_ctr_old,
    input  init_busy, pred_resp_valid, pred_ctr, pred_taken
  );

  modport slave (
    input  soft_init, pred_valid, pred_idx, upd_valid, upd_idx, upd_taken, upd_ctr_old,
    output init_busy, pred_resp_valid, pred_ctr, pred_taken
  );

endinterface

// File: rtl/tage_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read data 1 cycle after re.
// No back-pressure; same-address read/write returns the old contents.
module tage_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tage_base_table.sv
// TAGE T0 bimodal table: 1-cycle registered lookup, saturating update, sweep init after reset/soft_init.
// No back-pressure (requests outside RUN are dropped); TAGE_BASE_BYPASS_EN forwards same-index updates.
module tage_base_table
  import tage_pkg::*;
#(
  parameter int NUM_ENTRIES = TAGE_BASE_NUM_ENTRIES,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES),
  parameter int CTR_WIDTH   = TAGE_BASE_CTR_WIDTH,
  parameter logic [CTR_WIDTH-1:0] INIT_VALUE = CTR_WIDTH'(1 << (CTR_WIDTH - 1))
) (
  input  logic clk,
  input  logic rst_n,
  tage_base_table_if.slave bus
);

  tage_base_state_e     state, state_nxt;
  logic [IDX_WIDTH-1:0] sweep_idx, sweep_idx_nxt;
  logic                 run;

  logic [CTR_WIDTH-1:0] upd_new;
  logic                 upd_we;
  logic                 pred_acc;

  logic                 ram_we;
  logic [IDX_WIDTH-1:0] ram_waddr;
  logic [CTR_WIDTH-1:0] ram_wdata;
  logic [CTR_WIDTH-1:0] ram_rdata;

  logic                 resp_valid;
  logic [CTR_WIDTH-1:0] ctr_hold;
  logic [CTR_WIDTH-1:0] rd_val;
  logic [CTR_WIDTH-1:0] pred_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      INIT: begin
        if (bus.soft_init) begin
          sweep_idx_nxt = '0;
        end else if (sweep_idx == IDX_WIDTH'(NUM_ENTRIES - 1)) begin
          state_nxt     = RUN;
          sweep_idx_nxt = '0;
        end else begin
          sweep_idx_nxt = sweep_idx + 1'b1;
        end
      end
      RUN: begin
        if (bus.soft_init) begin
          state_nxt     = INIT;
          sweep_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt     = INIT;
        sweep_idx_nxt = '0;
      end
    endcase
  end

  assign run      = (state == RUN);
  assign pred_acc = run & bus.pred_valid;

  // Saturated updates leave the counter unchanged, so they skip the RAM write entirely.
  assign upd_new = bus.upd_taken
                 ? CTR_WIDTH'(sat_inc(ctr_max_t'(bus.upd_ctr_old), CTR_WIDTH))
                 : CTR_WIDTH'(sat_dec(ctr_max_t'(bus.upd_ctr_old), CTR_WIDTH));
  assign upd_we  = run & bus.upd_valid & (upd_new != bus.upd_ctr_old);

  assign ram_we    = !run | upd_we;
  assign ram_waddr = run ? bus.upd_idx : sweep_idx;
  assign ram_wdata = run ? upd_new : INIT_VALUE;

  tage_sdp_ram #(
    .DEPTH (NUM_ENTRIES),
    .AW    (IDX_WIDTH),
    .DW    (CTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (pred_acc),
    .raddr (bus.pred_idx),
    .rdata (ram_rdata)
  );

`ifdef TAGE_BASE_BYPASS_EN
  logic                 byp_hit;
  logic [CTR_WIDTH-1:0] byp_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit <= 1'b0;
      byp_dat <= '0;
    end else begin
      byp_hit <= pred_acc & upd_we & (bus.pred_idx == bus.upd_idx);
      byp_dat <= upd_new;
    end
  end

  assign rd_val = byp_hit ? byp_dat : ram_rdata;
`else
  assign rd_val = ram_rdata;
`endif

  // RAM output has no reset, so a reset-clean copy supplies the held value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      ctr_hold   <= '0;
    end else begin
      resp_valid <= pred_acc;
      if (resp_valid) begin
        ctr_hold <= rd_val;
      end
    end
  end

  assign pred_ctr            = resp_valid ? rd_val : ctr_hold;
  assign bus.pred_ctr        = pred_ctr;
  assign bus.pred_taken      = pred_ctr[CTR_WIDTH-1];
  assign bus.pred_resp_valid = resp_valid;
  assign bus.init_busy       = (state == INIT);

endmodule

// File: tb/tb_tage_base_table.sv
// Directed bench for tage_base_table (512 x 2-bit); collision expectation follows TAGE_BASE_BYPASS_EN.
module tb_tage_base_table;

  localparam int N  = 512;
  localparam int IW = 9;
  localparam int CW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tage_base_table_if #(.IDX_WIDTH(IW), .CTR_WIDTH(CW)) bus ();

  tage_base_table #(
    .NUM_ENTRIES (N),
    .IDX_WIDTH   (IW),
    .CTR_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic lookup(input int idx, output logic vld, output logic [CW-1:0] ctr,
                        output logic tk);
    @(negedge clk);
    bus.pred_valid = 1'b1;
    bus.pred_idx   = IW'(idx);
    @(negedge clk);
    vld = bus.pred_resp_valid;
    ctr = bus.pred_ctr;
    tk  = bus.pred_taken;
    bus.pred_valid = 1'b0;
  endtask

  task automatic check_lookup(input string tag, input int idx, input logic [CW-1:0] exp);
    logic          vld;
    logic [CW-1:0] ctr;
    logic          tk;
    lookup(idx, vld, ctr, tk);
    check({tag, "_vld"}, 32'(vld), 32'd1);
    check(tag, 32'(ctr), 32'(exp));
    check({tag, "_taken"}, 32'(tk), 32'(exp[CW-1]));
  endtask

  task automatic update(input int idx, input logic tk, input logic [CW-1:0] old);
    @(negedge clk);
    bus.upd_valid   = 1'b1;
    bus.upd_idx     = IW'(idx);
    bus.upd_taken   = tk;
    bus.upd_ctr_old = old;
    @(negedge clk);
    bus.upd_valid = 1'b0;
  endtask

  // Counts negedges with init_busy high; a runaway sweep stops at the bound and fails the count check.
  task automatic count_busy(inout int n);
    while (bus.init_busy && n < 4 * N) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int            n;
    int            bad;
    logic          vld;
    logic [CW-1:0] ctr;
    logic          tk;

    bus.soft_init   = 1'b0;
    bus.pred_valid  = 1'b0;
    bus.pred_idx    = '0;
    bus.upd_valid   = 1'b0;
    bus.upd_idx     = '0;
    bus.upd_taken   = 1'b0;
    bus.upd_ctr_old = '0;

    repeat (3) @(negedge clk);
    check("rst_resp_vld", 32'(bus.pred_resp_valid), 32'd0);
    check("rst_pred_ctr", 32'(bus.pred_ctr), 32'd0);
    check("rst_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_busy", 32'(bus.init_busy), 32'd1);

    rst_n = 1'b1;
    n = 0;
    count_busy(n);
    check("init_busy_cycles", 32'(n), 32'd512);
    check_lookup("init_idx0", 0, 2'd2);
    check_lookup("init_idx255", 255, 2'd2);
    check_lookup("init_idx511", 511, 2'd2);

    update(7, 1'b1, 2'd3);
    check_lookup("sat_inc_nowrite", 7, 2'd2);
    update(7, 1'b1, 2'd2);
    check_lookup("inc_to_3", 7, 2'd3);
    update(7, 1'b1, 2'd3);
    check_lookup("sat_inc_at_3", 7, 2'd3);
    update(7, 1'b0, 2'd1);
    check_lookup("dec_to_0", 7, 2'd0);
    update(7, 1'b0, 2'd0);
    check_lookup("sat_dec_at_0", 7, 2'd0);
    update(7, 1'b1, 2'd1);
    check_lookup("inc_from_1", 7, 2'd2);

    @(negedge clk);
    check("idle_resp_vld", 32'(bus.pred_resp_valid), 32'd0);
    check("idle_ctr_hold", 32'(bus.pred_ctr), 32'd2);

    @(negedge clk);
    bus.pred_valid  = 1'b1;
    bus.pred_idx    = IW'(42);
    bus.upd_valid   = 1'b1;
    bus.upd_idx     = IW'(42);
    bus.upd_taken   = 1'b0;
    bus.upd_ctr_old = 2'd2;
    @(negedge clk);
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    check("coll_vld", 32'(bus.pred_resp_valid), 32'd1);
`ifdef TAGE_BASE_BYPASS_EN
    check("coll_ctr", 32'(bus.pred_ctr), 32'd1);
`else
    check("coll_ctr", 32'(bus.pred_ctr), 32'd2);
`endif
    check_lookup("coll_after", 42, 2'd1);

    @(negedge clk);
    bus.pred_valid  = 1'b1;
    bus.pred_idx    = IW'(43);
    bus.upd_valid   = 1'b1;
    bus.upd_idx     = IW'(44);
    bus.upd_taken   = 1'b1;
    bus.upd_ctr_old = 2'd2;
    @(negedge clk);
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    check("indep_pred43", 32'(bus.pred_ctr), 32'd2);
    check_lookup("indep_upd44", 44, 2'd3);

    update(9, 1'b0, 2'd1);
    check_lookup("idx9_zero", 9, 2'd0);
    @(negedge clk);
    bus.soft_init = 1'b1;
    @(negedge clk);
    bus.soft_init = 1'b0;
    check("soft_busy_rise", 32'(bus.init_busy), 32'd1);
    n = 0;
    repeat (300) begin
      if (bus.init_busy) n++;
      @(negedge clk);
    end
    bus.pred_valid  = 1'b1;
    bus.pred_idx    = IW'(20);
    bus.upd_valid   = 1'b1;
    bus.upd_idx     = IW'(20);
    bus.upd_taken   = 1'b1;
    bus.upd_ctr_old = 2'd2;
    if (bus.init_busy) n++;
    @(negedge clk);
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    check("init_pred_ignored", 32'(bus.pred_resp_valid), 32'd0);
    check("init_ctr_hold", 32'(bus.pred_ctr), 32'd0);
    count_busy(n);
    check("soft_busy_cycles", 32'(n), 32'd512);
    check_lookup("soft_idx9", 9, 2'd2);
    check_lookup("init_upd_dropped", 20, 2'd2);

    update(300, 1'b1, 2'd2);
    check_lookup("idx300_pre", 300, 2'd3);
    @(negedge clk);
    bus.soft_init = 1'b1;
    @(negedge clk);
    bus.soft_init = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_resp_vld", 32'(bus.pred_resp_valid), 32'd0);
    check("midrst_pred_ctr", 32'(bus.pred_ctr), 32'd0);
    check("midrst_taken", 32'(bus.pred_taken), 32'd0);
    check("midrst_busy", 32'(bus.init_busy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    count_busy(n);
    check("midrst_busy_cycles", 32'(n), 32'd512);
    check_lookup("midrst_idx300", 300, 2'd2);

    bad = 0;
    for (int i = 0; i < N; i++) begin
      lookup(i, vld, ctr, tk);
      if (vld !== 1'b1 || ctr !== 2'd2 || tk !== 1'b1) bad++;
    end
    check("all_entries_init", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
